pipelined_cselect_adder: RTL
============================

PIPELINED_CSELECT_ADDER -- requirements
Module: pipelined_cselect_adder

Interface
REQ-001 Parameter M, default 32: operand and sum width in bits.
REQ-002 Parameter N, default 4: carry-select block width in bits; M SHALL be an integer multiple of N, with N <= M.
REQ-003 Derived constant S = M/N: number of blocks, which is also the number of pipeline stages.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  the input operand set is valid this cycle.
REQ-007 in_ready  output  1  the block accepts an operand set this cycle.
REQ-008 a  input  M  operand A (unsigned, or two's complement).
REQ-009 b  input  M  operand B.
REQ-010 cin  input  1  carry-in; used for add only.
REQ-011 sub  input  1  0 = A+B+cin; 1 = A-B.
REQ-012 out_valid  output  1  sum, cout and ovf are valid.
REQ-013 out_ready  input  1  the downstream consumer accepts the result.
REQ-014 sum  output  M  result.
REQ-015 cout  output  1  carry-out; for subtract, 1 = no borrow (A >= B unsigned).
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Effective operands: B' = sub ? ~b : b; c0 = sub ? 1 : cin.
REQ-018 Input handshake: an operand set is accepted when in_valid && in_ready.
REQ-019 Output handshake: a result is consumed when out_valid && out_ready.
REQ-020 Global advance enable: adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-021 All pipeline registers, including valid bits, SHALL update only when adv = 1.
REQ-022 When adv = 0, all pipeline registers SHALL hold.
REQ-023 Stage k (k = 1..S) SHALL resolve bits [kN-1:(k-1)N] and nothing else.
REQ-024 Stage k structure: compute both candidate block sums (carry-in 0 and carry-in 1) and select between them using the carry registered by stage k-1 (c0 for stage 1).
REQ-025 Data forwarded through the stages: operand bits not yet summed move forward; already-resolved sum bits move forward; the block carry moves forward.
REQ-026 The valid bit moves forward alongside the data.
REQ-027 Stage S carry SHALL produce cout.
REQ-028 ovf = carry into bit M-1 XOR carry out of bit M-1, registered with the final stage.
REQ-029 Latency: with out_ready held at 1, a set accepted at edge t SHALL appear with out_valid = 1 after edge t+S-1, i.e. visible in the cycle following edge t+S-1.
REQ-030 Throughput: one result per cycle. Results SHALL be delivered in acceptance order, none dropped, none duplicated.
REQ-031 Stall: while out_valid && !out_ready, sum, cout and ovf SHALL be held stable, and in_ready SHALL be 0.
REQ-032 Bubbles: in_valid = 0 on an advancing cycle SHALL inject a bubble (valid 0) that flows through the pipeline without producing output.
REQ-033 Simultaneous events: a stage fed by a bubble SHALL still advance. No "fill bubbles under stall" is required.
REQ-034 Simultaneous events: accept and consume in the same cycle SHALL both take effect.
REQ-035 The mode (sub) SHALL be captured per operand set; mixed add/sub streams SHALL compute independently.
REQ-036 Wrap-around: sum is modulo 2^M. The carry out of bit M-1 SHALL appear only on cout.
REQ-037 S = 1 (N = M) SHALL be legal: single stage, latency 1.

Reset
REQ-038 rst_n = 0 SHALL immediately, without waiting for a clock edge, clear all stage valid bits and set out_valid = 0.
REQ-039 rst_n = 0 SHALL also clear sum = 0, cout = 0, ovf = 0 and all internal data and carry registers to 0.
REQ-040 While rst_n = 0, in_ready SHALL be 1 (pipeline empty), but no operand set SHALL be captured.
REQ-041 Reset mid-operation SHALL discard all in-flight operand sets. No stale result SHALL appear after release.
REQ-042 The first operand set accepted after release SHALL obey REQ-029.

Verification (M=32, N=4, S=8 unless stated)
REQ-043 Add, full carry ripple: a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 -> 8 cycles later sum=0x00000000, cout=1, ovf=0.
REQ-044 Subtract with borrow: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-045 Signed overflow and carry-in: a=0x7FFFFFFF, b=0, cin=1, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-046 Stalled stream: 20 back-to-back random sets; out_ready=0 for 3 cycles mid-stream -> results in order match a reference model, sum held stable while stalled, in_ready=0 during the stall.
REQ-047 Reset mid-stream: 5 sets in flight, rst_n pulsed low between edges -> out_valid falls asynchronously; after release no output until a new set is accepted, which arrives after 8 cycles.
REQ-048 Single stage: M=8, N=8, a=0xF0, b=0x20 -> next cycle sum=0x10, cout=1.

Source files
------------

// File: rtl/pipelined_cselect_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_cselect_adder_if
//   Operand/result bus for pipelined_cselect_adder.
//   master : producer of operands and consumer of results (e.g. testbench)
//   slave  : the adder itself
//
//   in_valid  / in_ready  : operand handshake (a, b, cin, sub)
//   out_valid / out_ready : result handshake (sum, cout, ovf)
// ---------------------------------------------------------------------------
interface pipelined_cselect_adder_if #(
  parameter int M = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cselect_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cselect_adder
//   M-bit adder/subtractor built from S = M/N carry-select blocks, one block
//   per pipeline stage. Stage k resolves sum bits [kN-1:(k-1)N] by choosing
//   between two precomputed block sums with the carry registered by the
//   previous stage. A single advance enable stalls the whole pipeline when
//   the result is valid but not taken.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of pipelined_cselect_adder_if
//             in : in_valid, a, b, cin, sub, out_ready
//             out: in_ready, out_valid, sum, cout, ovf
// ---------------------------------------------------------------------------
module pipelined_cselect_adder #(
  parameter int M = 32,
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipelined_cselect_adder_if.slave    bus
);

  localparam int S = M / N;

  if ((N < 1) || (N > M) || ((M % N) != 0)) begin : g_param_check
    $error("pipelined_cselect_adder: M must be a positive multiple of N");
  end

  // Global advance: every stage moves together unless the output is stalled.
  logic w_adv;
  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Pipeline registers, one entry per stage. Operands travel unchanged; the
  // sum word accumulates one resolved block per stage, upper bits still 0.
  logic [M-1:0] r_a   [S];
  logic [M-1:0] r_b   [S];
  logic [M-1:0] r_sum [S];
  logic         r_c   [S];
  logic         r_v   [S];
  logic         r_ovf;

  logic [M-1:0] w_a_nxt   [S];
  logic [M-1:0] w_b_nxt   [S];
  logic [M-1:0] w_sum_nxt [S];
  logic         w_c_nxt   [S];
  logic         w_v_nxt   [S];
  logic         w_ovf_nxt;

  for (genvar g = 0; g < S; g++) begin : g_stage
    logic [M-1:0] w_a_in;
    logic [M-1:0] w_b_in;
    logic [M-1:0] w_sum_in;
    logic         w_c_in;
    logic         w_v_in;
    logic [N:0]   w_cand0;
    logic [N:0]   w_cand1;
    logic [N:0]   w_sel;

    if (g == 0) begin : g_first
      // Subtract is A + ~B + 1; the mode is folded into the operand here so
      // later stages never need to know whether the set is add or subtract.
      assign w_a_in   = bus.a;
      assign w_b_in   = bus.sub ? ~bus.b : bus.b;
      assign w_sum_in = '0;
      assign w_c_in   = bus.sub | bus.cin;
      assign w_v_in   = bus.in_valid;
    end else begin : g_next
      assign w_a_in   = r_a[g-1];
      assign w_b_in   = r_b[g-1];
      assign w_sum_in = r_sum[g-1];
      assign w_c_in   = r_c[g-1];
      assign w_v_in   = r_v[g-1];
    end

    // Both candidates are formed independently of the incoming carry.
    assign w_cand0 = {1'b0, w_a_in[g*N +: N]} + {1'b0, w_b_in[g*N +: N]};
    assign w_cand1 = {1'b0, w_a_in[g*N +: N]} + {1'b0, w_b_in[g*N +: N]} + (N+1)'(1);
    assign w_sel   = w_c_in ? w_cand1 : w_cand0;

    assign w_a_nxt[g]   = w_a_in;
    assign w_b_nxt[g]   = w_b_in;
    assign w_sum_nxt[g] = w_sum_in | (M'(w_sel[N-1:0]) << (g*N));
    assign w_c_nxt[g]   = w_sel[N];
    assign w_v_nxt[g]   = w_v_in;
  end

  // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
  assign w_ovf_nxt = w_a_nxt[S-1][M-1] ^ w_b_nxt[S-1][M-1]
                   ^ w_sum_nxt[S-1][M-1] ^ w_c_nxt[S-1];

  // NOTE: state uses non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor; data registers are reset too, not
  // just valid bits, so no stale operand is ever observable after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < S; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_sum[i] <= '0;
        r_c[i]   <= 1'b0;
        r_v[i]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int i = 0; i < S; i++) begin
        r_a[i]   <= w_a_nxt[i];
        r_b[i]   <= w_b_nxt[i];
        r_sum[i] <= w_sum_nxt[i];
        r_c[i]   <= w_c_nxt[i];
        r_v[i]   <= w_v_nxt[i];
      end
      r_ovf <= w_ovf_nxt;
    end
  end

  assign bus.out_valid = r_v[S-1];
  assign bus.sum       = r_sum[S-1];
  assign bus.cout      = r_c[S-1];
  assign bus.ovf       = r_ovf;

endmodule
